mac_result_collector: RTL and testbench

//  Downstream end of the MAC result interface (valid_out/f). Captures each
//  MAC result into a FIFO and re-presents it as a valid/ready stream.
//  The MAC pipeline cannot stall, so the block tracks MAC issues that are
//  in flight and grants can_issue only when a FIFO slot is reserved for

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_result_collector_sync_fifo.sv | 80 ++++++++
 rtl/mac_result_collector.sv | 118 +++++++++++
 tb/tb_mac_result_collector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and types for the MAC datapath and the
// blocks that sit around it.
//   MAC_WIDTH    - width of the MAC result f
//   MAC_IN_WIDTH - width of the MAC multiplier operands
//   MAC_LATENCY  - cycles from MAC valid_in to valid_out
//   mac_result_t - signed MAC result
package mac_pkg;

  localparam int MAC_WIDTH    = 28;
  localparam int MAC_IN_WIDTH = 14;
  localparam int MAC_LATENCY  = 5;

  typedef logic signed [MAC_WIDTH-1:0] mac_result_t;

endpackage : mac_pkg

// File: rtl/mac_result_collector_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage, pointers and
// occupancy count. No bypass: a write becomes visible at o_dout on the
// cycle after it is made.
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset; clears pointers, count, storage
//   i_push   in   write request
//   i_pop    in   read request (ignored when empty)
//   i_din    in   write data
//   o_dout   out  head entry, mem[rd_ptr]
//   o_count  out  occupancy 0..DEPTH
//   o_full   out  count == DEPTH
//   o_empty  out  count == 0
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == {CW{1'b0}});
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_wr_en = i_push & (~w_full | i_pop);
  assign w_rd_en = i_pop & ~w_empty;

  // Storage, pointer and occupancy update; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule : sync_fifo

// File: rtl/mac_result_collector.sv
// mac_result_collector: captures MAC results into a FIFO and re-presents
// them as a valid/ready stream. Because the MAC cannot stall, an issue is
// only granted (can_issue) when a FIFO slot is guaranteed for its result:
// stored results plus results still inside the MAC must stay below DEPTH.
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   issue_in   in   upstream starts a MAC operation this cycle
//   can_issue  out  upstream may assert issue_in this cycle
//   mac_valid  in   MAC valid_out
//   mac_f      in   MAC result
//   out_data   out  head-of-FIFO result
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts out_data
//   count      out  FIFO occupancy
//   ovf_err    out  sticky: a result was dropped on a full FIFO
//   proto_err  out  sticky: unexpected mac_valid or issue without grant
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_in,
  output logic                    can_issue,
  input  logic                    mac_valid,
  input  logic signed [WIDTH-1:0] mac_f,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW-1:0]           count,
  output logic                    ovf_err,
  output logic                    proto_err
);

  logic [CW-1:0]    r_inflight;
  logic             r_ovf_err;
  logic             r_proto_err;

  logic [WIDTH-1:0] w_dout;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_ovf;
  logic             w_proto;
  logic [CW:0]      w_occupied;

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (mac_valid),
    .i_pop   (w_pop),
    .i_din   (mac_f),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Reserved slots = stored results + results still in the MAC pipeline.
  // Uses registered state only, so a pop frees a slot one cycle later.
  assign w_occupied = {1'b0, w_count} + {1'b0, r_inflight};
  assign can_issue  = (w_occupied < (CW + 1)'(DEPTH));

  assign w_ovf   = mac_valid & w_full & ~w_pop;
  assign w_proto = (mac_valid & (r_inflight == {CW{1'b0}})) | (issue_in & ~can_issue);

  // In-flight tracking; saturates at 0 and DEPTH instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= {CW{1'b0}};
    end else begin
      case ({issue_in, mac_valid})
        2'b10: begin
          if (r_inflight != CW'(DEPTH)) begin
            r_inflight <= r_inflight + CW'(1);
          end else begin
            r_inflight <= r_inflight;
          end
        end
        2'b01: begin
          if (r_inflight != {CW{1'b0}}) begin
            r_inflight <= r_inflight - CW'(1);
          end else begin
            r_inflight <= r_inflight;
          end
        end
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_ovf_err   <= r_ovf_err | w_ovf;
      r_proto_err <= r_proto_err | w_proto;
    end
  end

  assign out_data  = w_dout;
  assign count     = w_count;
  assign ovf_err   = r_ovf_err;
  assign proto_err = r_proto_err;

endmodule : mac_result_collector

// File: tb/tb_mac_result_collector.sv
module tb_mac_result_collector;
  import mac_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_in = 1'b0;
  logic        can_issue;
  logic        mac_valid = 1'b0;
  mac_result_t mac_f = '0;
  mac_result_t out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [CW-1:0] count;
  logic        ovf_err;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  // bench MAC pipeline model
  logic        pv [MAC_LATENCY];
  mac_result_t pd [MAC_LATENCY];
  mac_result_t next_f = '0;

  // scoreboard / reference state
  mac_result_t sb_q[$];
  int  minf   = 0;
  bit  movf   = 1'b0;
  bit  mproto = 1'b0;
  bit  chk_en = 1'b0;
  int  n_pop  = 0;

  always #5 clk = ~clk;

  mac_result_collector #(.WIDTH(MAC_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .issue_in(issue_in), .can_issue(can_issue),
    .mac_valid(mac_valid), .mac_f(mac_f), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .ovf_err(ovf_err), .proto_err(proto_err)
  );

  // One clock cycle: check state and update the reference model on the
  // falling edge, then advance the MAC pipeline model after the rising edge.
  task automatic tick();
    bit exp_ci, pop, full;
    int sz;
    @(negedge clk);
    sz     = sb_q.size();
    exp_ci = (sz + minf) < DEPTH;
    if (chk_en) begin
      total++;
      if (out_valid !== (sz != 0)) begin bad++; $display("FAIL cyc_out_valid got=%0b want=%0b t=%0t", out_valid, (sz != 0), $time); end
      total++;
      if (count !== CW'(sz)) begin bad++; $display("FAIL cyc_count got=%0d want=%0d t=%0t", count, sz, $time); end
      total++;
      if (can_issue !== exp_ci) begin bad++; $display("FAIL cyc_can_issue got=%0b want=%0b t=%0t", can_issue, exp_ci, $time); end
      total++;
      if (ovf_err !== movf) begin bad++; $display("FAIL cyc_ovf_err got=%0b want=%0b t=%0t", ovf_err, movf, $time); end
      total++;
      if (proto_err !== mproto) begin bad++; $display("FAIL cyc_proto_err got=%0b want=%0b t=%0t", proto_err, mproto, $time); end
    end
    if (reset) begin
      sb_q.delete();
      minf = 0; movf = 1'b0; mproto = 1'b0;
    end else begin
      full = (sz == DEPTH);
      pop  = (sz != 0) && out_ready;
      if (pop) begin
        total++;
        if (out_data !== sb_q[0]) begin bad++; $display("FAIL sb_data got=%0d want=%0d t=%0t", out_data, sb_q[0], $time); end
        void'(sb_q.pop_front());
        n_pop++;
      end
      if (mac_valid) begin
        if (!full || pop) sb_q.push_back(mac_f);
        else movf = 1'b1;
        if (minf == 0) mproto = 1'b1;
      end
      if (issue_in && !exp_ci) mproto = 1'b1;
      if (issue_in && !mac_valid && minf < DEPTH) minf++;
      else if (!issue_in && mac_valid && minf > 0) minf--;
    end
    @(posedge clk);
    #1;
    for (int i = MAC_LATENCY - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = issue_in;
    pd[0] = next_f;
    if (issue_in) next_f = mac_result_t'($urandom);
    if (reset) begin
      for (int i = 0; i < MAC_LATENCY; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    end
    mac_valid = pv[MAC_LATENCY-1];
    mac_f     = pv[MAC_LATENCY-1] ? pd[MAC_LATENCY-1] : '0;
    issue_in  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // issue while granted; returns number of issues made
  task automatic fill_issues(output int n);
    n = 0;
    for (int i = 0; i < 30 && can_issue; i++) begin
      issue_in = 1'b1;
      n++;
      tick();
    end
  endtask

  task automatic wait_count(input int want, input string name);
    for (int i = 0; i < 30 && count !== CW'(want); i++) tick();
    total++;
    if (count !== CW'(want)) begin bad++; $display("FAIL %s_timeout count=%0d want=%0d", name, count, want); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < MAC_LATENCY; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (count !== '0)       begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== '0)    begin bad++; $display("FAIL rst_out_data got=%0d want=0", out_data); end
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL rst_can_issue got=%0b want=1", can_issue); end
    total++; if (ovf_err !== 1'b0)   begin bad++; $display("FAIL rst_ovf_err got=%0b want=0", ovf_err); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%0b want=0", proto_err); end
    chk_en = 1'b1;
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    next_f    = 28'sd1234;
    issue_in  = 1'b1;
    tick();
    repeat (MAC_LATENCY - 1) tick();
    total++; if (mac_valid !== 1'b1) begin bad++; $display("FAIL single_latency mac_valid got=%0b want=1", mac_valid); end
    tick();
    total++; if (count !== CW'(1))   begin bad++; $display("FAIL single_count got=%0d want=1", count); end
    total++; if (out_data !== 28'sd1234) begin bad++; $display("FAIL single_data got=%0d want=1234", out_data); end
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL single_can_issue got=%0b want=1", can_issue); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain out_valid got=%0b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    fill_issues(n);
    total++; if (n != DEPTH)         begin bad++; $display("FAIL bp_issues got=%0d want=%0d", n, DEPTH); end
    total++; if (can_issue !== 1'b0) begin bad++; $display("FAIL bp_can_issue got=%0b want=0", can_issue); end
    wait_count(DEPTH, "bp_fill");
    total++; if (ovf_err !== 1'b0)   begin bad++; $display("FAIL bp_ovf_err got=%0b want=0", ovf_err); end
  endtask

  task automatic test_full_push_pop();
    int p0;
    mac_valid = 1'b1;
    mac_f     = -28'sd5;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (count !== CW'(DEPTH)) begin bad++; $display("FAIL fpp_count got=%0d want=%0d", count, DEPTH); end
    p0 = n_pop;
    out_ready = 1'b1;
    wait_count(0, "fpp_drain");
    out_ready = 1'b0;
    total++; if (n_pop - p0 != DEPTH) begin bad++; $display("FAIL fpp_pops got=%0d want=%0d", n_pop - p0, DEPTH); end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    out_ready = 1'b0;
    fill_issues(n);
    wait_count(DEPTH, "ovf_fill");
    mac_valid = 1'b1;
    mac_f     = 28'sd777;
    tick();
    total++; if (ovf_err !== 1'b1)     begin bad++; $display("FAIL ovf_set got=%0b want=1", ovf_err); end
    total++; if (count !== CW'(DEPTH)) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", count, DEPTH); end
    repeat (3) tick();
    out_ready = 1'b1;
    wait_count(0, "ovf_drain");
    out_ready = 1'b0;
    total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", ovf_err); end
  endtask

  task automatic test_proto();
    int n;
    do_reset();
    mac_valid = 1'b1;
    mac_f     = 28'sd11;
    tick();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_mac got=%0b want=1", proto_err); end
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL proto_can_issue got=%0b want=1", can_issue); end
    // inflight held at 0, so exactly DEPTH-1 grants remain beside the stored result
    fill_issues(n);
    total++; if (n != DEPTH - 1) begin bad++; $display("FAIL proto_inflight_sat grants=%0d want=%0d", n, DEPTH - 1); end
    do_reset();
    fill_issues(n);
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_clean got=%0b want=0", proto_err); end
    issue_in = 1'b1;
    tick();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_issue got=%0b want=1", proto_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    mac_valid = 1'b1;
    mac_f     = 28'sd3;
    tick();
    repeat (4) begin issue_in = 1'b1; tick(); end
    repeat (3) tick();
    total++; if (count !== CW'(3))   begin bad++; $display("FAIL mid_count_pre got=%0d want=3", count); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL mid_proto_pre got=%0b want=1", proto_err); end
    do_reset();
    total++; if (count !== '0)       begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%0b want=0", out_valid); end
    total++; if (can_issue !== 1'b1) begin bad++; $display("FAIL mid_can_issue got=%0b want=1", can_issue); end
    total++; if (ovf_err !== 1'b0)   begin bad++; $display("FAIL mid_ovf got=%0b want=0", ovf_err); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL mid_proto got=%0b want=0", proto_err); end
    repeat (MAC_LATENCY + 2) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_push_pop();
    test_overflow();
    test_proto();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mac_result_collector
